// File: rtl/sar_adc_sequencer.sv
// rtl/sar_adc_sequencer.sv - multi-channel scan scheduler for one SAR ADC controller
// Settles the mux, pulses adc_start, averages 2**AVG_LOG2 conversions and hands results downstream.
module sar_adc_sequencer #(
   parameter int BITS        = 8,
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int AVG_LOG2    = 2,
   parameter int SETTLE_CYC  = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trigger,
   input  logic              continuous,
   input  logic              stop,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic [CH_W-1:0]   mux_sel,
   output logic              adc_start,
   input  logic [BITS-1:0]   adc_val,
   input  logic              adc_out_valid,
   output logic [BITS-1:0]   result_data,
   output logic [CH_W-1:0]   result_ch,
   output logic              result_err,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              busy
);

   localparam int ACC_W  = BITS + AVG_LOG2;
   localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int NSAMP  = 1 << AVG_LOG2;
   localparam int SET_W  = $clog2(SETTLE_CYC + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_CONVERT,
      S_OUTPUT
   } state_t;

   state_t            state_q;
   logic [NUM_CH-1:0] mask_q;
   logic              cont_q;
   logic [CH_W-1:0]   mux_sel_q;
   logic              adc_start_q;
   logic              vld_prev_q;
   logic [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]  samp_cnt_q;
   logic [SET_W-1:0]  settle_cnt_q;
   logic [TMO_W-1:0]  tmo_cnt_q;
   logic [BITS-1:0]   result_data_q;
   logic [CH_W-1:0]   result_ch_q;
   logic              result_err_q;
   logic              result_valid_q;
   logic              busy_q;

   logic [ACC_W-1:0]  acc_d;
   logic              valid_rise;
   logic              samp_last;
   logic [CH_W:0]     start_hit;
   logic [CH_W:0]     next_hit;
   logic [CH_W:0]     wrap_hit;

   // Returns {found, index} of the lowest set bit of m at or above position lo.
   function automatic logic [CH_W:0] first_from(input logic [NUM_CH-1:0] m, input int lo);
      logic [CH_W:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i] && (i >= lo)) begin
            r = {1'b1, CH_W'(i)};
         end
      end
      return r;
   endfunction

   assign start_hit  = first_from(ch_mask, 0);
   assign next_hit   = first_from(mask_q, int'(mux_sel_q) + 1);
   assign wrap_hit   = first_from(mask_q, 0);
   assign valid_rise = adc_out_valid & ~vld_prev_q;
   assign acc_d      = acc_q + ACC_W'(adc_val);
   assign samp_last  = (32'(samp_cnt_q) == 32'(NSAMP - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         mask_q         <= '0;
         cont_q         <= 1'b0;
         mux_sel_q      <= '0;
         adc_start_q    <= 1'b0;
         vld_prev_q     <= 1'b0;
         acc_q          <= '0;
         samp_cnt_q     <= '0;
         settle_cnt_q   <= '0;
         tmo_cnt_q      <= '0;
         result_data_q  <= '0;
         result_ch_q    <= '0;
         result_err_q   <= 1'b0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         vld_prev_q  <= adc_out_valid;
         adc_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (trigger && start_hit[CH_W]) begin
                  mask_q       <= ch_mask;
                  cont_q       <= continuous;
                  mux_sel_q    <= start_hit[CH_W-1:0];
                  settle_cnt_q <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                  adc_start_q <= 1'b1;
                  state_q     <= S_START;
               end else begin
                  settle_cnt_q <= settle_cnt_q + 1'b1;
               end
            end
            S_START: begin
               tmo_cnt_q <= '0;
               state_q   <= S_CONVERT;
            end
            S_CONVERT: begin
               if (valid_rise) begin
                  if (!samp_last) begin
                     acc_q       <= acc_d;
                     samp_cnt_q  <= samp_cnt_q + 1'b1;
                     adc_start_q <= 1'b1;
                     state_q     <= S_START;
                  end else begin
                     acc_q          <= acc_d;
                     result_data_q  <= acc_d[ACC_W-1:AVG_LOG2];
                     result_ch_q    <= mux_sel_q;
                     result_err_q   <= 1'b0;
                     result_valid_q <= 1'b1;
                     state_q        <= S_OUTPUT;
                  end
               end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                  result_data_q  <= '0;
                  result_ch_q    <= mux_sel_q;
                  result_err_q   <= 1'b1;
                  result_valid_q <= 1'b1;
                  state_q        <= S_OUTPUT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_OUTPUT: begin
               if (result_ready) begin
                  result_valid_q <= 1'b0;
                  acc_q          <= '0;
                  samp_cnt_q     <= '0;
                  settle_cnt_q   <= '0;
                  if (next_hit[CH_W]) begin
                     mux_sel_q <= next_hit[CH_W-1:0];
                     state_q   <= S_SETTLE;
                  end else if (cont_q && !stop && wrap_hit[CH_W]) begin
                     mux_sel_q <= wrap_hit[CH_W-1:0];
                     state_q   <= S_SETTLE;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mux_sel      = mux_sel_q;
   assign adc_start    = adc_start_q;
   assign result_data  = result_data_q;
   assign result_ch    = result_ch_q;
   assign result_err   = result_err_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// tb/tb_sar_adc_sequencer.sv - directed self-checking bench for sar_adc_sequencer
// A small ADC responder model answers adc_start; results are logged on every valid&&ready transfer.
module tb_sar_adc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       trigger;
   logic       continuous;
   logic       stop;
   logic [3:0] ch_mask;
   logic [1:0] mux_sel;
   logic       adc_start;
   logic [7:0] adc_val = 8'h00;
   logic       adc_out_valid = 1'b0;
   logic [7:0] result_data;
   logic [1:0] result_ch;
   logic       result_err;
   logic       result_valid;
   logic       result_ready;
   logic       busy;

   int vectors = 0;
   int errs    = 0;

   // ADC model controls, written only by the stimulus block
   logic [7:0] base_val   = 8'h00;
   logic       seq_en     = 1'b0;
   int         start_base = 0;
   logic       fail_en    = 1'b0;
   logic [1:0] fail_ch    = 2'd0;
   logic       force_high = 1'b0;
   int         conv_cyc   = 3;

   // ADC model state, written only by the model
   int         start_cnt = 0;
   logic       pending   = 1'b0;
   int         cd        = 0;
   logic [7:0] kval      = 8'h00;

   logic [10:0] res_q[$];

   always #5 clk = ~clk;

   sar_adc_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .trigger      (trigger),
      .continuous   (continuous),
      .stop         (stop),
      .ch_mask      (ch_mask),
      .mux_sel      (mux_sel),
      .adc_start    (adc_start),
      .adc_val      (adc_val),
      .adc_out_valid(adc_out_valid),
      .result_data  (result_data),
      .result_ch    (result_ch),
      .result_err   (result_err),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy)
   );

   always @(posedge clk) begin
      if (adc_start) start_cnt <= start_cnt + 1;
      if (force_high) begin
         adc_out_valid <= 1'b1;
         pending       <= 1'b0;
      end else if (adc_start) begin
         adc_out_valid <= 1'b0;
         if (!(fail_en && mux_sel == fail_ch)) begin
            pending <= 1'b1;
            cd      <= conv_cyc;
            kval    <= seq_en ? base_val + 8'(start_cnt - start_base) : base_val;
         end
      end else if (pending) begin
         if (cd == 0) begin
            adc_out_valid <= 1'b1;
            adc_val       <= kval;
            pending       <= 1'b0;
         end else begin
            cd <= cd - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (result_valid && result_ready) res_q.push_back({result_err, result_ch, result_data});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_trigger(input logic [3:0] m, input logic cont);
      @(negedge clk);
      trigger    = 1'b1;
      ch_mask    = m;
      continuous = cont;
      @(negedge clk);
      trigger    = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string tag);
      int n;
      n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n0;
      int s0;
      int n;
      rst_n        = 1'b0;
      trigger      = 1'b0;
      continuous   = 1'b0;
      stop         = 1'b0;
      ch_mask      = 4'b0000;
      result_ready = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, result_valid}, 32'd0);
      chk("rst_start", {31'd0, adc_start}, 32'd0);
      chk("rst_mux",   {30'd0, mux_sel}, 32'd0);
      chk("rst_data",  {24'd0, result_data}, 32'd0);
      chk("rst_err",   {31'd0, result_err}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single pass over ch0 and ch2
      base_val = 8'h40;
      n0 = res_q.size();
      s0 = start_cnt;
      pulse_trigger(4'b0101, 1'b0);
      wait_idle(2000, "t1_idle");
      chk("t1_count", res_q.size() - n0, 32'd2);
      chk("t1_res0", 32'(res_q[n0]), {21'd0, 1'b0, 2'd0, 8'h40});
      chk("t1_res1", 32'(res_q[n0 + 1]), {21'd0, 1'b0, 2'd2, 8'h40});
      chk("t1_starts", start_cnt - s0, 32'd8);

      // averaging of 10,11,12,13 on ch1
      base_val   = 8'd10;
      seq_en     = 1'b1;
      start_base = start_cnt;
      n0 = res_q.size();
      s0 = start_cnt;
      pulse_trigger(4'b0010, 1'b0);
      wait_idle(2000, "t2_idle");
      chk("t2_count", res_q.size() - n0, 32'd1);
      chk("t2_res", 32'(res_q[n0]), {21'd0, 1'b0, 2'd1, 8'd11});
      chk("t2_starts", start_cnt - s0, 32'd4);
      seq_en = 1'b0;

      // back-pressure on the ch0 result, then ch1 follows
      base_val     = 8'h55;
      result_ready = 1'b0;
      n0 = res_q.size();
      pulse_trigger(4'b0011, 1'b0);
      n = 0;
      while (!result_valid && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("t3_valid_up", {31'd0, result_valid}, 32'd1);
      s0 = start_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", {31'd0, result_valid}, 32'd1);
         chk("t3_hold_data", {24'd0, result_data}, 32'h55);
         chk("t3_hold_ch", {30'd0, result_ch}, 32'd0);
         chk("t3_no_start", {31'd0, adc_start}, 32'd0);
      end
      chk("t3_starts_frozen", start_cnt - s0, 32'd0);
      result_ready = 1'b1;
      wait_idle(2000, "t3_idle");
      chk("t3_count", res_q.size() - n0, 32'd2);
      chk("t3_res1", 32'(res_q[n0 + 1]), {21'd0, 1'b0, 2'd1, 8'h55});

      // ch0 never answers, ch1 does
      base_val = 8'h22;
      fail_en  = 1'b1;
      fail_ch  = 2'd0;
      n0 = res_q.size();
      s0 = start_cnt;
      pulse_trigger(4'b0011, 1'b0);
      wait_idle(3000, "t4_idle");
      fail_en = 1'b0;
      chk("t4_count", res_q.size() - n0, 32'd2);
      chk("t4_res0", 32'(res_q[n0]), {21'd0, 1'b1, 2'd0, 8'h00});
      chk("t4_res1", 32'(res_q[n0 + 1]), {21'd0, 1'b0, 2'd1, 8'h22});
      chk("t4_starts", start_cnt - s0, 32'd5);

      // continuous ch3 until stop
      base_val = 8'h33;
      n0 = res_q.size();
      s0 = start_cnt;
      pulse_trigger(4'b1000, 1'b1);
      n = 0;
      while (res_q.size() < n0 + 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("t5_three_results", res_q.size() - n0, 32'd3);
      chk("t5_still_busy", {31'd0, busy}, 32'd1);
      stop = 1'b1;
      wait_idle(2000, "t5_idle");
      stop = 1'b0;
      chk("t5_count", res_q.size() - n0, 32'd4);
      chk("t5_starts", start_cnt - s0, 32'd16);
      for (int i = 0; i < 4; i++) begin
         chk("t5_res", 32'(res_q[n0 + i]), {21'd0, 1'b0, 2'd3, 8'h33});
      end

      // stale high adc_out_valid, then reset mid-conversion
      force_high = 1'b1;
      repeat (3) @(negedge clk);
      n0 = res_q.size();
      s0 = start_cnt;
      pulse_trigger(4'b0001, 1'b0);
      repeat (20) @(negedge clk);
      chk("t6_busy", {31'd0, busy}, 32'd1);
      chk("t6_no_valid", {31'd0, result_valid}, 32'd0);
      chk("t6_no_result", res_q.size() - n0, 32'd0);
      chk("t6_one_start", start_cnt - s0, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy",  {31'd0, busy}, 32'd0);
      chk("t6_rst_valid", {31'd0, result_valid}, 32'd0);
      chk("t6_rst_start", {31'd0, adc_start}, 32'd0);
      chk("t6_rst_mux",   {30'd0, mux_sel}, 32'd0);
      chk("t6_rst_data",  {24'd0, result_data}, 32'd0);
      chk("t6_rst_ch",    {30'd0, result_ch}, 32'd0);
      chk("t6_rst_err",   {31'd0, result_err}, 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      force_high = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_post_idle", {31'd0, busy}, 32'd0);

      // trigger with an empty mask is ignored
      pulse_trigger(4'b0000, 1'b0);
      repeat (10) @(negedge clk);
      chk("t6_mask0_idle", {31'd0, busy}, 32'd0);
      chk("t6_mask0_valid", {31'd0, result_valid}, 32'd0);
      chk("t6_mask0_results", res_q.size() - n0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
